mem_stage_lsu: RTL and testbench
================================

// Module: mem_stage_lsu
// PURPOSE
//  Consumer side of the EX/MEM pipeline register: the RV32 MEM-stage load/store unit.
//  - Takes the latched ALU result (address), store data and control from EX/MEM.
//  - Runs loads and stores on a req/gnt/rvalid data-memory bus.
//  - Stalls the upstream pipeline while an access is in flight.
//  - Registers the writeback bundle (MEM/WB side) for the WB stage.
// PARAMETERS
//  TIMEOUT   255  cycles in REQ+RESP before the access is aborted with exc_bus
//  CNT_W     8    width of timeout counter; must hold TIMEOUT
// PORTS
//  clk           in   1   clock, rising edge
//  rst           in   1   asynchronous reset, active-high
//  flush         in   1   kill instruction currently in MEM (synchronous)
//  memRW         in   1   1 = store
//  MemReg        in   2   WB source: 00 alu, 01 mem (load), 10 pc+4; 11 treated as 00
//  RegW          in   1   register write enable
//  rd            in   5   destination register
//  funct3        in   3   access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
//  alu_in        in   32  ALU result / effective address
//  data_in       in   32  store data (rs2)
//  pc_add4       in   32  pc+4 for jal/jalr writeback
//  stall         out  1   hold IF..EX/MEM; upstream keeps inputs stable while 1
//  dmem_req      out  1   bus request
//  dmem_we       out  1   1 = write
//  dmem_addr     out  32  word-aligned address ({alu_in[31:2],2'b00})
//  dmem_be       out  4   byte enables
//  dmem_wdata    out  32  lane-shifted store data
//  dmem_gnt      in   1   request accepted this cycle
//  dmem_rvalid   in   1   read data valid
//  dmem_rdata    in   32  read data
//  wb_valid      out  1   writeback bundle valid
//  wb_RegW       out  1   register write enable to WB
//  wb_rd         out  5   destination register to WB
//  wb_data       out  32  writeback value
//  exc_misaligned out 1   one-cycle pulse: misaligned access, no bus traffic
//  exc_bus       out  1   one-cycle pulse: timeout abort
// BEHAVIOUR
//  - Reset: state IDLE, counter 0, all outputs 0 (incl. wb_*, dmem_*, stall). rst mid-access
//    drops dmem_req immediately; the memory side is reset by the same rst.
//  - access = memRW | (MemReg==01). Misaligned: h/hu with addr[0]=1, w with addr[1:0]!=0.
//  - FSM states: IDLE, REQ, RESP.
//  - IDLE:
//    - No access: wb_* <= inputs next edge (latency 1).
//      wb_data = alu_in, or pc_add4 when MemReg==10.
//    - Aligned access: capture addr/be/wdata/funct3/rd; go to REQ; stall=1.
//    - Misaligned: exc_misaligned pulses at the next edge; wb_valid=1, wb_RegW=0; no dmem_req; no stall.
//  - REQ: dmem_req=1; fields held stable until gnt.
//    - gnt & store: go to IDLE; stall=0 that cycle; wb_RegW=0.
//    - gnt & load: go to RESP.
//  - RESP: stall=1 until dmem_rvalid.
//    - On rvalid: stall=0; wb_data <= extracted lane; go to IDLE.
//      - Lane = addr[1:0]; b/h sign-extended; bu/hu zero-extended.
//  - Stores: be b=0001<<a[1:0], h=0011<<a[1:0], w=1111; wdata replicated/shifted to the lane.
//  - Timeout: counter clears on IDLE->REQ and counts in REQ/RESP.
//    - At TIMEOUT: exc_bus pulses; go to IDLE; stall=0; wb_RegW=0; late rvalid ignored.
//  - flush:
//    - IDLE: wb_valid/wb_RegW <= 0.
//    - REQ before gnt: drop request, go to IDLE.
//    - RESP: transaction drains (stall held to rvalid); writeback suppressed.
//    - flush together with gnt: store still written (granted), load drains suppressed.
//  - Simultaneous gnt and rvalid in REQ: rvalid is ignored; the response arrives in RESP.
// STRUCTURE
//  - rv32_mem_pkg:
//    - funct3 load/store codes
//    - MemReg encodings (WB_ALU, WB_MEM, WB_PC4)
//    - lsu_state_t enum
//    - byte-enable constants
//  - Sub-module lsu_align: combinational be/wdata lane generation and load extract/extend.
//  - FSM, timeout counter and wb registers live in the top.
// TESTING
//  1 RegW=1 MemReg=00 alu_in=0x1234 rd=5 -> next cycle wb_data=0x1234 wb_rd=5 wb_RegW=1, stall=0
//  2 lw addr 0x100, gnt 1st REQ cycle, rvalid 2 cycles later rdata 0xDEADBEEF
//    -> dmem_addr=0x100 be=1111; stall drops in the rvalid cycle; wb_data=0xDEADBEEF
//  3 lb addr 0x103, rdata 0x80FFFFFF -> wb_data=0xFFFFFF80; same with lbu -> 0x00000080
//  4 sh addr 0x102 data_in 0x0000ABCD, gnt after 3 cycles
//    -> dmem_we=1 be=1100 wdata=0xABCD0000 held 3 cycles; wb_RegW=0
//  5 lw addr 0x101 -> exc_misaligned 1 cycle, dmem_req never 1, wb_RegW=0, stall=0
//  6 lw, gnt never -> exc_bus pulses after 255 cycles, stall releases
//    rst asserted mid-RESP -> all outputs 0 asynchronously

Source files
------------

// File: rtl/mem_stage_lsu_pkg.sv
// Shared encodings for the RV32 MEM-stage load/store unit.
// Holds funct3 codes, writeback selects, FSM states and byte-enable masks.
package rv32_mem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [1:0] WB_ALU = 2'b00;
   localparam logic [1:0] WB_MEM = 2'b01;
   localparam logic [1:0] WB_PC4 = 2'b10;

   localparam logic [3:0] BE_B = 4'b0001;
   localparam logic [3:0] BE_H = 4'b0011;
   localparam logic [3:0] BE_W = 4'b1111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_RESP = 2'd2
   } lsu_state_t;

   function automatic logic misaligned(input logic [2:0] f3,
                                       input logic [1:0] a);
      logic m;
      m = 1'b0;
      unique case (f3[1:0])
         2'b01:   m = a[0];
         2'b10:   m = (a != 2'b00);
         default: m = 1'b0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory req/gnt/rvalid bus between the LSU and memory.
// The LSU drives the master side, memory drives the slave side.
interface mem_stage_lsu_if;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic        dmem_gnt;
   logic        dmem_rvalid;
   logic [31:0] dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
      input  dmem_gnt, dmem_rvalid, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
      output dmem_gnt, dmem_rvalid, dmem_rdata
   );
endinterface

// File: rtl/mem_stage_lsu_align.sv
// Byte-lane steering: store enables/data shifted to the lane,
// load data pulled from the lane and sign/zero extended.
module lsu_align
   import rv32_mem_pkg::*;
(
   input  logic [2:0]  st_f3,
   input  logic [1:0]  st_lane,
   input  logic [31:0] st_data,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   input  logic [2:0]  ld_f3,
   input  logic [1:0]  ld_lane,
   input  logic [31:0] rdata,
   output logic [31:0] ld_data
);

   logic [31:0] sh;

   always_comb begin
      be    = BE_W;
      wdata = st_data;
      unique case (1'b1)
         (st_f3[1:0] == 2'b00): begin
            be    = BE_B << st_lane;
            wdata = {24'b0, st_data[7:0]} << {st_lane, 3'b000};
         end
         (st_f3[1:0] == 2'b01): begin
            be    = BE_H << st_lane;
            wdata = {16'b0, st_data[15:0]} << {st_lane, 3'b000};
         end
         default: begin
            be    = BE_W;
            wdata = st_data;
         end
      endcase
   end

   always_comb begin
      sh      = rdata >> {ld_lane, 3'b000};
      ld_data = sh;
      unique case (1'b1)
         (ld_f3 == F3_B):  ld_data = {{24{sh[7]}}, sh[7:0]};
         (ld_f3 == F3_BU): ld_data = {24'b0, sh[7:0]};
         (ld_f3 == F3_H):  ld_data = {{16{sh[15]}}, sh[15:0]};
         (ld_f3 == F3_HU): ld_data = {16'b0, sh[15:0]};
         default:          ld_data = sh;
      endcase
   end

endmodule

// File: rtl/mem_stage_lsu.sv
// RV32 MEM-stage load/store unit: EX/MEM consumer, dmem bus FSM,
// pipeline stall and registered MEM/WB writeback bundle.
module mem_stage_lsu
   import rv32_mem_pkg::*;
#(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        memRW,
   input  logic [1:0]  MemReg,
   input  logic        RegW,
   input  logic [4:0]  rd,
   input  logic [2:0]  funct3,
   input  logic [31:0] alu_in,
   input  logic [31:0] data_in,
   input  logic [31:0] pc_add4,
   output logic        stall,
   mem_stage_lsu_if.master dmem,
   output logic        wb_valid,
   output logic        wb_RegW,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        exc_misaligned,
   output logic        exc_bus
);

   lsu_state_t state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic access, misal, start, timeout;
   logic kill_q, we_q, regw_q, stall_c;
   logic [4:0]  rd_q;
   logic [2:0]  f3_q;
   logic [1:0]  lane_q;
   logic [31:0] addr_q, wdata_q, wdata_c, ld_c;
   logic [3:0]  be_q, be_c;

   assign access  = memRW | (MemReg == WB_MEM);
   assign misal   = access & misaligned(funct3, alu_in[1:0]);
   assign start   = (state_q == S_IDLE) & access & ~misal & ~flush;
   assign timeout = (state_q != S_IDLE)
                  & (cnt_q == CNT_W'(TIMEOUT - 1));

   lsu_align u_align (
      .st_f3   (funct3),
      .st_lane (alu_in[1:0]),
      .st_data (data_in),
      .be      (be_c),
      .wdata   (wdata_c),
      .ld_f3   (f3_q),
      .ld_lane (lane_q),
      .rdata   (dmem.dmem_rdata),
      .ld_data (ld_c)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (start) state_d = S_REQ;
         S_REQ: begin
            if (dmem.dmem_gnt)         state_d = we_q ? S_IDLE : S_RESP;
            else if (flush || timeout) state_d = S_IDLE;
         end
         S_RESP: if (dmem.dmem_rvalid || timeout) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      stall_c = 1'b0;
      unique case (state_q)
         S_IDLE: stall_c = start;
         S_REQ:  stall_c = dmem.dmem_gnt ? ~we_q : ~(flush | timeout);
         S_RESP: stall_c = ~(dmem.dmem_rvalid | timeout);
         default: stall_c = 1'b0;
      endcase
   end

   // Gate with rst so stall reads 0 while held in reset.
   assign stall           = stall_c & ~rst;
   assign dmem.dmem_req   = (state_q == S_REQ);
   assign dmem.dmem_we    = we_q;
   assign dmem.dmem_addr  = addr_q;
   assign dmem.dmem_be    = be_q;
   assign dmem.dmem_wdata = wdata_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= '0;
         kill_q  <= 1'b0;
         we_q    <= 1'b0;
         regw_q  <= 1'b0;
         rd_q    <= '0;
         f3_q    <= '0;
         lane_q  <= '0;
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
      end else begin
         if (start) begin
            cnt_q   <= '0;
            kill_q  <= 1'b0;
            we_q    <= memRW;
            regw_q  <= RegW;
            rd_q    <= rd;
            f3_q    <= funct3;
            lane_q  <= alu_in[1:0];
            addr_q  <= {alu_in[31:2], 2'b00};
            be_q    <= be_c;
            wdata_q <= wdata_c;
         end else if (state_q != S_IDLE) begin
            cnt_q <= cnt_q + 1'b1;
            if (flush) kill_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_valid       <= 1'b0;
         wb_RegW        <= 1'b0;
         wb_rd          <= '0;
         wb_data        <= '0;
         exc_misaligned <= 1'b0;
         exc_bus        <= 1'b0;
      end else begin
         wb_valid       <= 1'b0;
         wb_RegW        <= 1'b0;
         exc_misaligned <= 1'b0;
         exc_bus        <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (!flush && misal) begin
                  wb_valid       <= 1'b1;
                  wb_rd          <= rd;
                  wb_data        <= alu_in;
                  exc_misaligned <= 1'b1;
               end else if (!flush && !access) begin
                  wb_valid <= 1'b1;
                  wb_RegW  <= RegW;
                  wb_rd    <= rd;
                  wb_data  <= (MemReg == WB_PC4) ? pc_add4 : alu_in;
               end
            end
            S_REQ: begin
               if (dmem.dmem_gnt && we_q) begin
                  wb_valid <= ~(flush | kill_q);
                  wb_rd    <= rd_q;
               end else if (!dmem.dmem_gnt && !flush && timeout) begin
                  wb_valid <= 1'b1;
                  wb_rd    <= rd_q;
                  exc_bus  <= 1'b1;
               end
            end
            S_RESP: begin
               if (dmem.dmem_rvalid) begin
                  wb_valid <= ~(flush | kill_q);
                  wb_RegW  <= regw_q & ~(flush | kill_q);
                  wb_rd    <= rd_q;
                  wb_data  <= ld_c;
               end else if (timeout) begin
                  wb_valid <= 1'b1;
                  wb_rd    <= rd_q;
                  exc_bus  <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed self-checking bench for mem_stage_lsu.
// Each scenario task drives the EX/MEM inputs and the memory side by hand.
module tb_mem_stage_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush, memRW, RegW;
   logic [1:0]  MemReg;
   logic [4:0]  rd;
   logic [2:0]  funct3;
   logic [31:0] alu_in, data_in, pc_add4;
   logic        stall, wb_valid, wb_RegW, exc_misaligned, exc_bus;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   int total = 0;
   int bad = 0;

   mem_stage_lsu_if bus ();

   mem_stage_lsu dut (
      .clk            (clk),
      .rst            (rst),
      .flush          (flush),
      .memRW          (memRW),
      .MemReg         (MemReg),
      .RegW           (RegW),
      .rd             (rd),
      .funct3         (funct3),
      .alu_in         (alu_in),
      .data_in        (data_in),
      .pc_add4        (pc_add4),
      .stall          (stall),
      .dmem           (bus),
      .wb_valid       (wb_valid),
      .wb_RegW        (wb_RegW),
      .wb_rd          (wb_rd),
      .wb_data        (wb_data),
      .exc_misaligned (exc_misaligned),
      .exc_bus        (exc_bus)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic nop;
      flush = 0; memRW = 0; MemReg = 2'b00; RegW = 0; rd = 0;
      funct3 = 3'b010; alu_in = 0; data_in = 0; pc_add4 = 0;
   endtask

   task automatic load(input logic [31:0] a, input logic [2:0] f3,
                       input logic [4:0] r);
      nop;
      MemReg = 2'b01; RegW = 1; rd = r; funct3 = f3; alu_in = a;
   endtask

   task automatic test_reset;
      rst = 1;
      nop;
      bus.dmem_gnt = 0; bus.dmem_rvalid = 0; bus.dmem_rdata = 0;
      tick; tick;
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%0h exp=0", stall); end
      total++; if (bus.dmem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%0h exp=0", bus.dmem_req); end
      total++; if ({wb_valid, wb_RegW, wb_rd, wb_data} !== 39'd0) begin bad++; $display("FAIL rst_wb got=%h exp=0", {wb_valid, wb_RegW, wb_rd, wb_data}); end
      total++; if ({bus.dmem_addr, bus.dmem_be, bus.dmem_we} !== 37'd0) begin bad++; $display("FAIL rst_dmem got=%h exp=0", {bus.dmem_addr, bus.dmem_be}); end
      rst = 0;
      tick;
   endtask

   task automatic test_alu;
      RegW = 1; MemReg = 2'b00; alu_in = 32'h1234; rd = 5; pc_add4 = 32'h208;
      #1;
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL alu_stall got=%0h exp=0", stall); end
      tick;
      total++; if (wb_data !== 32'h1234) begin bad++; $display("FAIL alu_data got=%h exp=00001234", wb_data); end
      total++; if ({wb_valid, wb_RegW, wb_rd} !== {1'b1, 1'b1, 5'd5}) begin bad++; $display("FAIL alu_ctl got=%b exp=1100101", {wb_valid, wb_RegW, wb_rd}); end
      MemReg = 2'b10;
      tick;
      total++; if (wb_data !== 32'h208) begin bad++; $display("FAIL pc4_data got=%h exp=00000208", wb_data); end
      MemReg = 2'b11;
      tick;
      total++; if (wb_data !== 32'h1234) begin bad++; $display("FAIL mr11_data got=%h exp=00001234", wb_data); end
      flush = 1;
      tick;
      total++; if ({wb_valid, wb_RegW} !== 2'b00) begin bad++; $display("FAIL flush_idle got=%b exp=00", {wb_valid, wb_RegW}); end
      nop;
   endtask

   task automatic test_lw;
      load(32'h100, 3'b010, 5'd7);
      #1;
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL lw_stall_idle got=%0h exp=1", stall); end
      tick;
      total++; if ({bus.dmem_req, bus.dmem_we, bus.dmem_be} !== 6'b101111) begin bad++; $display("FAIL lw_req got=%b exp=101111", {bus.dmem_req, bus.dmem_we, bus.dmem_be}); end
      total++; if (bus.dmem_addr !== 32'h100) begin bad++; $display("FAIL lw_addr got=%h exp=00000100", bus.dmem_addr); end
      bus.dmem_gnt = 1;
      #1;
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL lw_stall_gnt got=%0h exp=1", stall); end
      tick;
      bus.dmem_gnt = 0;
      #1;
      total++; if ({bus.dmem_req, stall} !== 2'b01) begin bad++; $display("FAIL lw_resp got=%b exp=01", {bus.dmem_req, stall}); end
      tick;
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL lw_wait got=%0h exp=1", stall); end
      bus.dmem_rvalid = 1; bus.dmem_rdata = 32'hDEADBEEF;
      #1;
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL lw_stall_rv got=%0h exp=0", stall); end
      tick;
      bus.dmem_rvalid = 0;
      nop;
      total++; if (wb_data !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_data got=%h exp=deadbeef", wb_data); end
      total++; if ({wb_valid, wb_RegW, wb_rd} !== {1'b1, 1'b1, 5'd7}) begin bad++; $display("FAIL lw_ctl got=%b exp=1100111", {wb_valid, wb_RegW, wb_rd}); end
   endtask

   task automatic test_load_ext;
      logic [31:0] ta [6] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h101, 32'h100};
      logic [2:0]  tf [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b001};
      logic [31:0] tr [6] = '{32'h80FFFFFF, 32'h80FFFFFF, 32'h80011234,
                              32'h80011234, 32'h00007F00, 32'h0000FFFE};
      logic [31:0] te [6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001,
                              32'h00008001, 32'h0000007F, 32'hFFFFFFFE};
      for (int i = 0; i < 6; i++) begin
         load(ta[i], tf[i], 5'd9);
         tick;
         bus.dmem_gnt = 1;
         tick;
         bus.dmem_gnt = 0; bus.dmem_rvalid = 1; bus.dmem_rdata = tr[i];
         tick;
         bus.dmem_rvalid = 0;
         nop;
         total++; if (wb_data !== te[i]) begin bad++; $display("FAIL ld_ext%0d got=%h exp=%h", i, wb_data, te[i]); end
      end
   endtask

   task automatic test_store;
      nop;
      memRW = 1; RegW = 1; funct3 = 3'b001; alu_in = 32'h102; data_in = 32'h0000ABCD;
      tick;
      for (int i = 0; i < 3; i++) begin
         total++; if ({bus.dmem_req, bus.dmem_we, bus.dmem_be, stall} !== 7'b1111001) begin bad++; $display("FAIL sh_hold%0d got=%b exp=1111001", i, {bus.dmem_req, bus.dmem_we, bus.dmem_be, stall}); end
         total++; if (bus.dmem_wdata !== 32'hABCD0000) begin bad++; $display("FAIL sh_wdata%0d got=%h exp=abcd0000", i, bus.dmem_wdata); end
         tick;
      end
      bus.dmem_gnt = 1;
      #1;
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL sh_stall_gnt got=%0h exp=0", stall); end
      tick;
      bus.dmem_gnt = 0;
      nop;
      total++; if ({wb_valid, wb_RegW, bus.dmem_req} !== 3'b100) begin bad++; $display("FAIL sh_wb got=%b exp=100", {wb_valid, wb_RegW, bus.dmem_req}); end
      memRW = 1; funct3 = 3'b000; alu_in = 32'h101; data_in = 32'h12345677;
      tick;
      total++; if ({bus.dmem_be, bus.dmem_wdata} !== {4'b0010, 32'h00007700}) begin bad++; $display("FAIL sb_lane got=%h exp=200007700", {bus.dmem_be, bus.dmem_wdata}); end
      bus.dmem_gnt = 1;
      tick;
      bus.dmem_gnt = 0;
      nop;
   endtask

   task automatic test_misaligned;
      load(32'h101, 3'b010, 5'd3);
      #1;
      total++; if ({stall, bus.dmem_req} !== 2'b00) begin bad++; $display("FAIL mis_stall got=%b exp=00", {stall, bus.dmem_req}); end
      tick;
      total++; if ({exc_misaligned, wb_valid, wb_RegW, bus.dmem_req} !== 4'b1100) begin bad++; $display("FAIL mis_exc got=%b exp=1100", {exc_misaligned, wb_valid, wb_RegW, bus.dmem_req}); end
      nop;
      tick;
      total++; if (exc_misaligned !== 1'b0) begin bad++; $display("FAIL mis_pulse got=%0h exp=0", exc_misaligned); end
      load(32'h103, 3'b101, 5'd3);
      tick;
      total++; if ({exc_misaligned, bus.dmem_req} !== 2'b10) begin bad++; $display("FAIL mis_lhu got=%b exp=10", {exc_misaligned, bus.dmem_req}); end
      nop;
   endtask

   task automatic test_timeout;
      int n;
      load(32'h200, 3'b010, 5'd4);
      tick;
      n = 0;
      while (stall && n < 400) begin
         tick;
         n++;
      end
      total++; if (n !== 254) begin bad++; $display("FAIL to_cycles got=%0d exp=254", n); end
      nop;
      tick;
      total++; if ({exc_bus, wb_RegW, stall, bus.dmem_req} !== 4'b1000) begin bad++; $display("FAIL to_exc got=%b exp=1000", {exc_bus, wb_RegW, stall, bus.dmem_req}); end
      bus.dmem_rvalid = 1; bus.dmem_rdata = 32'h55AA55AA;
      tick;
      bus.dmem_rvalid = 0;
      total++; if ({exc_bus, wb_RegW, wb_data} !== 34'd0) begin bad++; $display("FAIL to_late got=%h exp=0", {exc_bus, wb_RegW, wb_data}); end
   endtask

   task automatic test_flush;
      load(32'h300, 3'b010, 5'd6);
      tick;
      flush = 1;
      #1;
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL fl_req_stall got=%0h exp=0", stall); end
      tick;
      nop;
      total++; if ({bus.dmem_req, wb_valid, wb_RegW} !== 3'b000) begin bad++; $display("FAIL fl_req got=%b exp=000", {bus.dmem_req, wb_valid, wb_RegW}); end
      load(32'h304, 3'b010, 5'd6);
      tick;
      bus.dmem_gnt = 1;
      tick;
      bus.dmem_gnt = 0; flush = 1;
      #1;
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL fl_resp_stall got=%0h exp=1", stall); end
      tick;
      flush = 0; bus.dmem_rvalid = 1; bus.dmem_rdata = 32'h11112222;
      #1;
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL fl_drain got=%0h exp=0", stall); end
      tick;
      bus.dmem_rvalid = 0;
      nop;
      total++; if ({wb_valid, wb_RegW} !== 2'b00) begin bad++; $display("FAIL fl_resp_wb got=%b exp=00", {wb_valid, wb_RegW}); end
   endtask

   task automatic test_rst_mid;
      load(32'h400, 3'b010, 5'd8);
      tick;
      bus.dmem_gnt = 1;
      tick;
      bus.dmem_gnt = 0;
      #2;
      rst = 1;
      #1;
      total++; if ({stall, bus.dmem_req, bus.dmem_addr, wb_valid, wb_RegW} !== 36'd0) begin bad++; $display("FAIL rst_mid got=%h exp=0", {stall, bus.dmem_req, bus.dmem_addr, wb_valid, wb_RegW}); end
      nop;
      tick;
      rst = 0;
      tick;
      total++; if ({stall, bus.dmem_req, exc_bus} !== 3'b000) begin bad++; $display("FAIL rst_after got=%b exp=000", {stall, bus.dmem_req, exc_bus}); end
   endtask

   initial begin
      test_reset;
      test_alu;
      test_lw;
      test_load_ext;
      test_store;
      test_misaligned;
      test_timeout;
      test_flush;
      test_rst_mid;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
